// File: rtl/key_onehot_if.sv
// Key-scanner bus: raw key lines in, debounced one-hot code and status out.
// Latency is set by the attached block; there is no backpressure because the consumer samples levels and pulses.
interface key_onehot_if;
    logic [7:0] key;
    logic [7:0] onehot;
    logic       valid;
    logic       busy;
    logic       multi;

    modport master (output key, input onehot, valid, busy, multi);
    modport slave  (input key, output onehot, valid, busy, multi);
endinterface

// File: rtl/key_onehot.sv
// Key debouncer and one-hot encoder: 2-flop sync, stability counter, and an IDLE/HOLD/WAITREL latch FSM.
// Press and release latency is DEB_CYCLES+3 clocks; there is no backpressure, and valid is a single-cycle pulse.
module key_onehot #(
    parameter int DEB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    key_onehot_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HOLD, WAITREL} state_t;

    localparam logic [7:0] CNT_MAX  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] CNT_LOAD = 8'(DEB_CYCLES - 2);

    logic [7:0] s1, s2;
    logic [7:0] prev, cnt, stab;
    logic [7:0] acc;
    logic [7:0] onehot_q;
    logic       valid_q, busy_q, multi_q;
    state_t     state;

    logic [7:0] lowbit;
    logic       many;

    assign bus.onehot = onehot_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.multi  = multi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.key;
            s2 <= s1;
        end
    end

    // Any single-bit difference from the previous sample restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            cnt  <= '0;
            stab <= '0;
        end else begin
            prev <= s2;
            if (s2 != prev) begin
                cnt <= '0;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 8'd1;
                if (cnt == CNT_LOAD)
                    stab <= s2;
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit; clearing it reveals whether more remain.
    always_comb begin
        lowbit = stab & (~stab + 8'd1);
        many   = |(stab & (stab - 8'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (stab != 8'd0) begin
                        state    <= HOLD;
                        acc      <= stab;
                        onehot_q <= lowbit;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        multi_q  <= many;
                    end
                end
                HOLD: begin
                    if (stab == 8'd0) begin
                        state    <= IDLE;
                        onehot_q <= '0;
                        busy_q   <= 1'b0;
                        multi_q  <= 1'b0;
                    end else if (stab != acc) begin
                        state <= WAITREL;
                    end
                end
                WAITREL: begin
                    if (stab == 8'd0) begin
                        state    <= IDLE;
                        onehot_q <= '0;
                        busy_q   <= 1'b0;
                        multi_q  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    onehot_q <= '0;
                    busy_q   <= 1'b0;
                    multi_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/key_onehot.md
KEY_ONEHOT -- requirements
Module: key_onehot

Interface
REQ-001 Parameter DEB_CYCLES, default 4, meaning consecutive clocks the synchronized key vector must remain unchanged before it is accepted (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 key  input  8  raw key lines: asynchronous, active-high, may bounce.
REQ-005 onehot  output  8  registered one-hot key code for the downstream 8-to-3 encoder: exactly one bit set, or all zero.
REQ-006 valid  output  1  single-cycle pulse in the cycle onehot first takes a new nonzero value.
REQ-007 busy  output  1  high while a key is latched (state HOLD).
REQ-008 multi  output  1  sticky flag: set when an accepted vector had more than one bit set; cleared on the next return to IDLE.

Function
REQ-009 key SHALL pass through a 2-flop synchronizer per bit (s1, s2); no other logic SHALL sample raw key.
REQ-010 The debouncer SHALL hold prev (8 bits, last s2) and cnt (8 bits); when s2 != prev, cnt <= 0; otherwise cnt increments, saturating at DEB_CYCLES-1.
REQ-011 stab (8 bits) SHALL load s2 on the clock where s2 == prev and cnt == DEB_CYCLES-2, i.e. after s2 has been unchanged for DEB_CYCLES consecutive samples; a change of even one bit SHALL restart the count.
REQ-012 FSM states SHALL be IDLE, HOLD, WAITREL.
REQ-013 IDLE: onehot = 0, busy = 0; when stab != 0, go to HOLD, load onehot with the lowest-index set bit of stab, pulse valid for one cycle, set multi if stab has more than one bit set.
REQ-014 HOLD: onehot and multi hold; busy = 1; when stab == 0, go to IDLE, clear onehot and multi on that edge.
REQ-015 HOLD: a change of stab to a different nonzero vector SHALL NOT change onehot or pulse valid; go to WAITREL.
REQ-016 WAITREL: onehot holds, busy = 1; leave only when stab == 0, then to IDLE as in REQ-014; a new key is accepted only from IDLE.
REQ-017 onehot SHALL never have more than one bit set, in any cycle, including the cycle after reset.
REQ-018 valid SHALL never be high for two consecutive cycles and never coincident with onehot == 0.
REQ-019 Latency: with key stable from before clock edge 1, onehot/valid SHALL change after edge DEB_CYCLES+3 (7 for default); release latency SHALL be identical.
REQ-020 Bounce shorter than DEB_CYCLES clocks of stability SHALL produce no valid pulse and no onehot change.
REQ-021 Priority: simultaneous presses SHALL resolve to the lowest-index bit (key = 8'b1001_0100 -> onehot = 8'b0000_0100, multi = 1).
REQ-022 Each valid pulse SHALL correspond to exactly one press-release cycle of the debounced vector.

Reset
REQ-023 rst high SHALL immediately, without a clock, force s1, s2, prev, stab = 0, cnt = 0, state = IDLE, onehot = 0, valid = 0, busy = 0, multi = 0.
REQ-024 Reset asserted mid-HOLD SHALL clear outputs at once; after release, a key still held SHALL be re-accepted as a new press after DEB_CYCLES+3 edges with one valid pulse.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk by the system; the block needs no internal reset synchronizer.

Verification
REQ-026 Clean press: key = 8'h08 held 20 cycles, then 8'h00 -> valid pulse once at edge 7, onehot = 8'h08, busy = 1; onehot = 0, busy = 0 seven edges after release.
REQ-027 Bounce: key toggles 8'h00/8'h20 every 2 clocks for 12 clocks, then stays 8'h20 -> no valid during toggling; one valid, onehot = 8'h20, after 7 stable edges.
REQ-028 Multi-press: key = 8'h94 held -> onehot = 8'h04, multi = 1, one valid; release -> multi = 0.
REQ-029 Slide: key 8'h01 held 10 cycles, then 8'h03 10 cycles, then 8'h02 10 cycles, then 8'h00 -> onehot = 8'h01 throughout, exactly one valid, state passes through WAITREL.
REQ-030 Reset mid-hold: key = 8'h80 held, rst pulsed between clock edges during HOLD -> onehot = 0 immediately; after rst falls, valid re-pulses with onehot = 8'h80 at edge 7.
REQ-031 Walking sweep: each of the 8 single-bit keys pressed/released in turn -> 8 valid pulses, onehot equal to the key each time; downstream encoder output 0..7 in order.
